// File: rtl/sysref_period_tracker_pkg.sv
// Shared types and constants for the SYSREF period tracker.
package sysref_pkg;

  // Tracker state encoding, also exported on the state port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  // Width of the saturating early/late edge counter.
  localparam int ERR_W = 8;

endpackage

// File: rtl/sysref_period_tracker_if.sv
// Control and status bundle between the SYSREF capture side and the tracker.
interface sysref_period_tracker_if
  import sysref_pkg::*;
#(
  parameter int PERIOD_W = 16
);
  logic                sysref_adc;
  logic                en;
  logic                err_clr;
  logic                sysref_edge;
  logic                local_sysref;
  logic                locked;
  state_e              state;
  logic [PERIOD_W-1:0] period_meas;
  logic [ERR_W-1:0]    err_cnt;

  modport master (
    output sysref_adc, en, err_clr,
    input  sysref_edge, local_sysref, locked, state, period_meas, err_cnt
  );

  modport slave (
    input  sysref_adc, en, err_clr,
    output sysref_edge, local_sysref, locked, state, period_meas, err_cnt
  );
endinterface

// File: rtl/sysref_period_tracker_edge_det.sv
// Rising-edge detector for the captured SYSREF level; a level held high yields one edge.
module sysref_edge_det (
  input  logic pl_clk,
  input  logic pl_rst_n,
  input  logic sysref_adc,
  output logic rise
);
  logic sysref_q;

  // One-cycle delayed copy of the SYSREF level.
  always_ff @(posedge pl_clk or negedge pl_rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!pl_rst_n) sysref_q <= 1'b0;
    else           sysref_q <= sysref_adc;
  end

  assign rise = sysref_adc & ~sysref_q;
endmodule

// File: rtl/sysref_period_tracker.sv
// Locks to the periodic PL SYSREF, regenerates a flywheel pulse and reports period and errors.
module sysref_period_tracker
  import sysref_pkg::*;
#(
  parameter int PERIOD_W      = 16,
  parameter int SYSREF_PERIOD = 256,
  parameter int LOCK_COUNT    = 4,
  parameter int MISS_LIMIT    = 2
) (
  input logic                    pl_clk,
  input logic                    pl_rst_n,
  sysref_period_tracker_if.slave bus
);
  localparam logic [PERIOD_W-1:0] WRAP_VAL  = PERIOD_W'(SYSREF_PERIOD - 1);
  localparam int                  GOOD_W    = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int                  MISS_W    = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;
  localparam logic [GOOD_W-1:0]   GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]   MISS_LAST = MISS_W'(MISS_LIMIT - 1);
  localparam logic [ERR_W-1:0]    ERR_MAX   = '1;

  logic                rise;
  logic                wrap;
  logic                err_inc;
  state_e              state_q;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] ivl;
  logic                seen;
  logic [GOOD_W-1:0]   good;
  logic [MISS_W-1:0]   miss;
  logic                edge_q;
  logic                local_q;
  logic                locked_q;
  logic [PERIOD_W-1:0] period_q;
  logic [ERR_W-1:0]    err_q;

  sysref_edge_det u_edge_det (
    .pl_clk     (pl_clk),
    .pl_rst_n   (pl_rst_n),
    .sysref_adc (bus.sysref_adc),
    .rise       (rise)
  );

  // Decode the wrap cycle and whether this cycle's edge counts as early/late.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wrap    = 1'b0;
    err_inc = 1'b0;
    wrap    = (cnt == WRAP_VAL);
    err_inc = bus.en && rise && !wrap &&
              ((state_q == ST_ACQUIRE) || (state_q == ST_LOCKED));
  end

  // Tracker FSM with phase/interval counters and registered status outputs.
  always_ff @(posedge pl_clk or negedge pl_rst_n) begin
    if (!pl_rst_n) begin
      state_q  <= ST_IDLE;
      cnt      <= '0;
      ivl      <= '0;
      seen     <= 1'b0;
      good     <= '0;
      miss     <= '0;
      edge_q   <= 1'b0;
      local_q  <= 1'b0;
      locked_q <= 1'b0;
      period_q <= '0;
    end else if (!bus.en) begin
      // Disable wins over any edge: drop back to IDLE and forget the history.
      state_q  <= ST_IDLE;
      cnt      <= '0;
      ivl      <= '0;
      seen     <= 1'b0;
      good     <= '0;
      miss     <= '0;
      edge_q   <= 1'b0;
      local_q  <= 1'b0;
      locked_q <= 1'b0;
      period_q <= '0;
    end else begin
      edge_q  <= rise;
      local_q <= 1'b0;
      cnt     <= wrap ? '0 : cnt + 1'b1;

      // Edge-to-edge interval, armed by the first edge after enable.
      if (state_q != ST_IDLE) begin
        if (rise) begin
          ivl  <= PERIOD_W'(1);
          seen <= 1'b1;
          if (seen) period_q <= ivl;
        end else if (seen && (ivl != '1)) begin
          ivl <= ivl + 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          state_q <= ST_SEARCH;
          cnt     <= '0;
        end
        ST_SEARCH: begin
          cnt <= '0;
          if (rise) begin
            state_q <= ST_ACQUIRE;
            good    <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (rise) begin
            cnt <= '0;
            if (!wrap) begin
              good <= '0;
            end else if (good == GOOD_LAST) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
              good     <= '0;
              miss     <= '0;
            end else begin
              good <= good + 1'b1;
            end
          end else if (wrap) begin
            state_q <= ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (rise && wrap) begin
            cnt     <= '0;
            miss    <= '0;
            local_q <= 1'b1;
          end else if (rise) begin
            // Off-time edge: re-qualify the new phase from scratch.
            cnt      <= '0;
            good     <= '0;
            state_q  <= ST_ACQUIRE;
            locked_q <= 1'b0;
          end else if (wrap) begin
            if (miss == MISS_LAST) begin
              state_q  <= ST_SEARCH;
              locked_q <= 1'b0;
              miss     <= '0;
            end else begin
              miss    <= miss + 1'b1;
              local_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Saturating early/late counter; survives disable, clear beats increment.
  always_ff @(posedge pl_clk or negedge pl_rst_n) begin
    if (!pl_rst_n)                       err_q <= '0;
    else if (bus.err_clr)                err_q <= '0;
    else if (err_inc && err_q != ERR_MAX) err_q <= err_q + 1'b1;
  end

  assign bus.sysref_edge  = edge_q;
  assign bus.local_sysref = local_q;
  assign bus.locked       = locked_q;
  assign bus.state        = state_q;
  assign bus.period_meas  = period_q;
  assign bus.err_cnt      = err_q;
endmodule

// File: tb/tb_sysref_period_tracker.sv
// Directed bench for sysref_period_tracker with PERIOD=16, LOCK_COUNT=4, MISS_LIMIT=2.
module tb_sysref_period_tracker;
  import sysref_pkg::*;

  typedef struct packed {
    logic [1:0]  st;
    logic        lk;
    logic        ls;
    logic [15:0] pm;
    logic [7:0]  ec;
  } exp_t;

  logic pl_clk;
  logic pl_rst_n;
  int   n_checks;
  int   n_errors;
  int   extra;
  exp_t sb_q[$];

  sysref_period_tracker_if #(.PERIOD_W(16)) bus ();

  sysref_period_tracker #(
    .PERIOD_W      (16),
    .SYSREF_PERIOD (16),
    .LOCK_COUNT    (4),
    .MISS_LIMIT    (2)
  ) dut (
    .pl_clk   (pl_clk),
    .pl_rst_n (pl_rst_n),
    .bus      (bus)
  );

  initial pl_clk = 1'b0;
  always #5 pl_clk = ~pl_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of SYSREF level; returns #1 after the sampling edge.
  task automatic cyc(input logic s);
    bus.sysref_adc = s;
    @(posedge pl_clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".state"},  bus.state,        ST_IDLE);
    check({tag, ".locked"}, bus.locked,       0);
    check({tag, ".local"},  bus.local_sysref, 0);
    check({tag, ".edge"},   bus.sysref_edge,  0);
    check({tag, ".period"}, bus.period_meas,  0);
    check({tag, ".err"},    bus.err_cnt,      0);
  endtask

  // Pulse 'gap' cycles after the previous one; the expected status is queued
  // at drive time and compared when the DUT reports the edge.
  task automatic pulse(input string tag, input int gap, input logic [1:0] st, input logic lk,
                       input logic ls, input logic [15:0] pm, input logic [7:0] ec,
                       input logic clr);
    exp_t e;
    for (int i = 0; i < gap - 1; i++) cyc(1'b0);
    sb_q.push_back('{st: st, lk: lk, ls: ls, pm: pm, ec: ec});
    bus.err_clr = clr;
    cyc(1'b1);
    bus.err_clr = 1'b0;
    for (int k = 0; k < 3 && bus.sysref_edge !== 1'b1; k++) cyc(1'b1);
    check({tag, ".edge"}, bus.sysref_edge, 1);
    e = sb_q.pop_front();
    check({tag, ".state"},  bus.state,        e.st);
    check({tag, ".locked"}, bus.locked,       e.lk);
    check({tag, ".local"},  bus.local_sysref, e.ls);
    check({tag, ".period"}, bus.period_meas,  e.pm);
    check({tag, ".err"},    bus.err_cnt,      e.ec);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    pl_rst_n       = 1'b0;
    bus.en         = 1'b0;
    bus.err_clr    = 1'b0;
    bus.sysref_adc = 1'b0;

    // Reset, then released with enable low: nothing moves.
    repeat (3) cyc(1'b0);
    check_quiet("rst");
    pl_rst_n = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat (5) cyc(1'b0);
      check("idle.state", bus.state, ST_IDLE);
    end
    check_quiet("idle");

    // Acquire and lock on pulses every 16 cycles.
    bus.en = 1'b1;
    cyc(1'b0);
    check("en.state", bus.state, ST_SEARCH);
    pulse("acq1", 4, ST_ACQUIRE, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) pulse("acq", 16, ST_ACQUIRE, 0, 0, 16, 0, 0);
    pulse("lock", 16, ST_LOCKED, 1, 0, 16, 0, 0);
    pulse("locked1", 16, ST_LOCKED, 1, 1, 16, 0, 0);
    pulse("locked2", 16, ST_LOCKED, 1, 1, 16, 0, 0);

    // One missing pulse is flywheeled; two in a row drop to SEARCH.
    repeat (15) cyc(1'b0);
    check("miss1.pre_local", bus.local_sysref, 0);
    cyc(1'b0);
    check("miss1.local", bus.local_sysref, 1);
    check("miss1.locked", bus.locked, 1);
    check("miss1.state", bus.state, ST_LOCKED);
    pulse("after_miss", 16, ST_LOCKED, 1, 1, 32, 0, 0);
    repeat (16) cyc(1'b0);
    check("miss2a.local", bus.local_sysref, 1);
    check("miss2a.state", bus.state, ST_LOCKED);
    repeat (16) cyc(1'b0);
    check("miss2b.state", bus.state, ST_SEARCH);
    check("miss2b.locked", bus.locked, 0);
    check("miss2b.local", bus.local_sysref, 0);
    pulse("research", 5, ST_ACQUIRE, 0, 0, 37, 0, 0);
    for (int i = 0; i < 3; i++) pulse("reacq", 16, ST_ACQUIRE, 0, 0, 16, 0, 0);
    pulse("relock", 16, ST_LOCKED, 1, 0, 16, 0, 0);
    pulse("relocked", 16, ST_LOCKED, 1, 1, 16, 0, 0);

    // Early edge while locked.
    pulse("early", 10, ST_ACQUIRE, 0, 0, 10, 1, 0);
    for (int i = 0; i < 3; i++) pulse("early_acq", 16, ST_ACQUIRE, 0, 0, 16, 1, 0);
    pulse("early_relock", 16, ST_LOCKED, 1, 0, 16, 1, 0);
    pulse("early_locked", 16, ST_LOCKED, 1, 1, 16, 1, 0);

    // Level held high for 40 cycles: one edge only, then two missed wraps.
    pulse("hold_start", 16, ST_LOCKED, 1, 1, 16, 1, 0);
    extra = 0;
    repeat (39) begin
      cyc(1'b1);
      if (bus.sysref_edge === 1'b1) extra++;
    end
    check("hold.extra_edges", extra, 0);
    check("hold.state", bus.state, ST_SEARCH);
    check("hold.locked", bus.locked, 0);
    pulse("after_hold", 20, ST_ACQUIRE, 0, 0, 59, 1, 0);

    // Error counter: increment, clear winning over increment, saturation.
    pulse("early_acq2", 7, ST_ACQUIRE, 0, 0, 7, 2, 0);
    pulse("clr", 5, ST_ACQUIRE, 0, 0, 5, 0, 1);
    pulse("post_clr", 3, ST_ACQUIRE, 0, 0, 3, 1, 0);
    repeat (256) begin
      cyc(1'b0);
      cyc(1'b0);
      cyc(1'b1);
    end
    pulse("err_sat", 3, ST_ACQUIRE, 0, 0, 3, 255, 0);

    // Enable drop mid-ACQUIRE beats a simultaneous edge; err_cnt survives.
    cyc(1'b0);
    bus.en = 1'b0;
    cyc(1'b1);
    check("endrop.state", bus.state, ST_IDLE);
    check("endrop.edge", bus.sysref_edge, 0);
    check("endrop.period", bus.period_meas, 0);
    check("endrop.err", bus.err_cnt, 255);
    cyc(1'b0);
    bus.en = 1'b1;
    cyc(1'b0);
    check("reen.state", bus.state, ST_SEARCH);
    pulse("reen_first", 4, ST_ACQUIRE, 0, 0, 0, 255, 0);
    for (int i = 0; i < 3; i++) pulse("reen_acq", 16, ST_ACQUIRE, 0, 0, 16, 255, 0);
    pulse("reen_lock", 16, ST_LOCKED, 1, 0, 16, 255, 0);

    // Asynchronous reset while locked clears everything at once.
    repeat (5) cyc(1'b0);
    #3;
    pl_rst_n = 1'b0;
    #1;
    check_quiet("async_rst");
    @(posedge pl_clk);
    #1;
    check_quiet("async_rst_hold");
    pl_rst_n = 1'b1;
    cyc(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
